carrier_loop_regs_mc: RTL
=========================

Name: carrier_loop_regs_mc

Overview:
Multi-channel successor to the single-channel carrier-loop register bank. Holds lead/lag gains, limits, loop data and lock-detector settings for NUM_CH independent carrier loops behind one bus-slave port. Gain, limit, loop-data and lock settings are double-buffered (shadow to active), so a loop never sees a half-written 32-bit value. Adds a one-cycle clear-accumulator pulse and a sticky, write-1-to-clear lock-lost status per channel.

Parameters:
NUM_CH, 4, number of loop channels (1..16)
CH_BITS, 2, channel-select address width; must satisfy 2**CH_BITS >= NUM_CH
ADDR_W, 13, bus address width

Ports:
busClk  in  1  bus/system clock; all state updates on rising edge
nReset  in  1  synchronous active-low reset, sampled on busClk
cs  in  1  block select
wr0,wr1,wr2,wr3  in  1 each  byte-lane write enables (lane n = dataIn[8n+7:8n])
addr  in  ADDR_W  addr[2:0]=register index, addr[CH_BITS+2:3]=channel
dataIn  in  32  write data
dataOut  out  32  read data, combinational
loopUpdate  in  NUM_CH  per-channel loop-sample strobe (1 cycle)
lagAccum  in  32*NUM_CH  signed integrator per channel, channel c at [32c+31:32c]
lockStatus  in  NUM_CH  per-channel lock indication
invertError, zeroError, ctrl2, ctrl4, clearAccum  out  NUM_CH each  per-channel controls
acqTrackControl  out  2*NUM_CH
leadExp, lagExp  out  5*NUM_CH;  leadMan, lagMan  out  8*NUM_CH  (active copies)
upperLimit, lowerLimit, loopData  out  32*NUM_CH  (active copies)
lockCount  out  16*NUM_CH;  syncThreshold  out  12*NUM_CH  (active copies)
lockLost  out  NUM_CH  sticky status, mirrors STATUS[0]

Behaviour:
- Write occurs when cs & wrN on the busClk edge; each lane is independent. Field placement per register matches the existing map. Writes to channel >= NUM_CH or to a read-only register are ignored.
- Register index map:
  - 0 CONTROL: [0] zeroError, [1] invertError, [2] ctrl2, [3] clearAccum, [4] ctrl4, [9:8] acqTrackControl, [16] commit. Bit 31 reads lockStatus.
  - 1 LEAD_LAG: lagExp [4:0], lagMan [15:8], leadExp [20:16], leadMan [31:24].
  - 2 ULIMIT.
  - 3 LLIMIT.
  - 4 LOOPDATA.
  - 5 LOCKDET: lockCount [15:0], syncThreshold [27:16].
  - 6 INTEGRATOR (RO).
  - 7 STATUS: [0] lockLost (W1C), [1] pending (RO).
- CONTROL fields other than bits 3 and 16 are unbuffered; outputs change on the edge after the write.
- clearAccum: writing 1 to CONTROL[3] produces exactly one busClk cycle high on clearAccum[c]. The bit reads back 0.
- Registers 1-5 are double-buffered:
  - Any write to a register 1-5 updates the shadow copy and sets pending[c].
  - On loopUpdate[c] with pending[c]=1, all shadow fields are copied to active and pending[c] clears.
  - Active outputs change only at that edge.
  - Writing 1 to CONTROL[16] (lane wr2) copies shadow to active on the next edge regardless of loopUpdate and clears pending. The bit reads back 0.
- Simultaneous write and loopUpdate on the same channel: active takes the pre-write shadow, the new byte lands in shadow, pending stays 1.
- Simultaneous commit and loopUpdate: single copy, pending=0.
- Reads of registers 1-5 return the shadow copy.
- lockLost: lockStatus is registered once; a 1->0 transition of the registered value sets lockLost[c] one cycle later.
- Writing 1 to STATUS[0] (wr0) clears lockLost. If set and clear coincide, set wins.
- dataOut is combinational. It returns 32'h0 when cs=0, for unmapped channels, and for reserved bits; no X values.
- INTEGRATOR returns lagAccum of the addressed channel, unregistered.
- Reset (nReset=0 at an edge), shadow and active:
  - all fields 0, except upperLimit=32'h7FFF_FFFF and lowerLimit=32'h8000_0000;
  - pending=0, lockLost=0, clearAccum=0;
  - lockStatus pipeline reset to 0, so no false lockLost after reset;
  - reset overrides any concurrent write or loopUpdate.

Test Plan:
- Reset, then read every register of all channels -> ULIMIT=7FFF_FFFF, LLIMIT=8000_0000, all others 0; all outputs at those values; no X on dataOut.
- Ch2 ULIMIT wr0 only with 32'h1234_5678 -> shadow/readback 7FFF_FF78, STATUS[1]=1, upperLimit ch2 unchanged. loopUpdate[2] pulse -> active 7FFF_FF78, pending 0. Other channels untouched.
- Ch1 LEAD_LAG write 32'h0A03_1402 in the same cycle as loopUpdate[1] with prior shadow 0 -> active stays 0, pending=1. Next loopUpdate[1] -> leadMan=0A, leadExp=03, lagMan=14, lagExp=02.
- Ch0 CONTROL write 32'h0001_0008 with a pending LOCKDET write -> clearAccum[0] high exactly 1 cycle; LOCKDET active updated next edge without loopUpdate; CONTROL reads 0.
- Drive lockStatus[3] 1->0 -> lockLost[3]=1 two edges later. W1C on the same cycle as a new fall -> remains 1. Plain W1C -> 0.
- Write ch3 with NUM_CH=3 and assert nReset=0 mid-sequence -> out-of-range write ignored; all state returns to reset values on the next edge.

Source files
------------

// File: rtl/carrier_loop_regs_mc.sv
// Multi-channel carrier-loop register bank: per-channel loop controls, shadow/active
// double-buffered gain, limit, loop-data and lock-detector settings, sticky lock-lost status.
module carrier_loop_regs_mc #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_BITS = 2,
    parameter int unsigned ADDR_W  = 13
) (
    input  logic                   busClk,
    input  logic                   nReset,
    input  logic                   cs,
    input  logic                   wr0,
    input  logic                   wr1,
    input  logic                   wr2,
    input  logic                   wr3,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [31:0]            dataIn,
    output logic [31:0]            dataOut,
    input  logic [NUM_CH-1:0]      loopUpdate,
    input  logic [32*NUM_CH-1:0]   lagAccum,
    input  logic [NUM_CH-1:0]      lockStatus,
    output logic [NUM_CH-1:0]      invertError,
    output logic [NUM_CH-1:0]      zeroError,
    output logic [NUM_CH-1:0]      ctrl2,
    output logic [NUM_CH-1:0]      ctrl4,
    output logic [NUM_CH-1:0]      clearAccum,
    output logic [2*NUM_CH-1:0]    acqTrackControl,
    output logic [5*NUM_CH-1:0]    leadExp,
    output logic [5*NUM_CH-1:0]    lagExp,
    output logic [8*NUM_CH-1:0]    leadMan,
    output logic [8*NUM_CH-1:0]    lagMan,
    output logic [32*NUM_CH-1:0]   upperLimit,
    output logic [32*NUM_CH-1:0]   lowerLimit,
    output logic [32*NUM_CH-1:0]   loopData,
    output logic [16*NUM_CH-1:0]   lockCount,
    output logic [12*NUM_CH-1:0]   syncThreshold,
    output logic [NUM_CH-1:0]      lockLost
);

    localparam logic [2:0] REG_CONTROL    = 3'd0;
    localparam logic [2:0] REG_LEAD_LAG   = 3'd1;
    localparam logic [2:0] REG_ULIMIT     = 3'd2;
    localparam logic [2:0] REG_LLIMIT     = 3'd3;
    localparam logic [2:0] REG_LOOPDATA   = 3'd4;
    localparam logic [2:0] REG_LOCKDET    = 3'd5;
    localparam logic [2:0] REG_INTEGRATOR = 3'd6;
    localparam logic [2:0] REG_STATUS     = 3'd7;

    localparam logic [31:0] ULIMIT_RST = 32'h7FFF_FFFF;
    localparam logic [31:0] LLIMIT_RST = 32'h8000_0000;

    // Buffered loop settings; one copy as shadow, one as active.
    typedef struct packed {
        logic [7:0]  lead_man;
        logic [4:0]  lead_exp;
        logic [7:0]  lag_man;
        logic [4:0]  lag_exp;
        logic [31:0] upper;
        logic [31:0] lower;
        logic [31:0] loop_data;
        logic [15:0] lock_count;
        logic [11:0] sync_thr;
    } loop_cfg_t;

    localparam loop_cfg_t CFG_RST = '{
        lead_man:   8'h0,
        lead_exp:   5'h0,
        lag_man:    8'h0,
        lag_exp:    5'h0,
        upper:      ULIMIT_RST,
        lower:      LLIMIT_RST,
        loop_data:  32'h0,
        lock_count: 16'h0,
        sync_thr:   12'h0
    };

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [3:0]         lane_we_c;
    logic [CH_BITS-1:0] ch_sel_c;
    logic [2:0]         reg_sel_c;
    logic               ch_ok_c;
    logic [31:0]        rd_word_c [NUM_CH];
    logic               addr_unused;

    assign lane_we_c   = {wr3, wr2, wr1, wr0} & {4{cs}};
    assign ch_sel_c    = addr[CH_BITS+2:3];
    assign reg_sel_c   = addr[2:0];
    assign ch_ok_c     = 32'(ch_sel_c) < NUM_CH;
    assign addr_unused = ^addr[ADDR_W-1:CH_BITS+3];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        loop_cfg_t   shadow_q;
        loop_cfg_t   shadow_d;
        loop_cfg_t   active_q;
        logic        pending_q;
        logic        lost_q;
        logic        lock_q;
        logic        lock_d1_q;
        logic        clear_q;
        logic        zero_q;
        logic        inv_q;
        logic        ctrl2_q;
        logic        ctrl4_q;
        logic [1:0]  acq_q;
        logic        sel_c;
        logic        cfg_wr_c;
        logic        commit_c;
        logic        clear_c;
        logic        w1c_c;
        logic        copy_c;
        logic [31:0] rd_c;

        assign sel_c    = ch_ok_c && (32'(ch_sel_c) == 32'(c)) && (|lane_we_c);
        assign cfg_wr_c = sel_c && (reg_sel_c >= REG_LEAD_LAG) && (reg_sel_c <= REG_LOCKDET);
        assign commit_c = sel_c && (reg_sel_c == REG_CONTROL) && lane_we_c[2] && dataIn[16];
        assign clear_c  = sel_c && (reg_sel_c == REG_CONTROL) && lane_we_c[0] && dataIn[3];
        assign w1c_c    = sel_c && (reg_sel_c == REG_STATUS) && lane_we_c[0] && dataIn[0];
        // Active always takes the pre-write shadow, so a concurrent write stays pending.
        assign copy_c   = commit_c || (loopUpdate[c] && pending_q);

        always_comb begin
            shadow_d = shadow_q;
            if (sel_c) begin
                case (reg_sel_c)
                    REG_LEAD_LAG: begin
                        if (lane_we_c[0]) shadow_d.lag_exp  = dataIn[4:0];
                        if (lane_we_c[1]) shadow_d.lag_man  = dataIn[15:8];
                        if (lane_we_c[2]) shadow_d.lead_exp = dataIn[20:16];
                        if (lane_we_c[3]) shadow_d.lead_man = dataIn[31:24];
                    end
                    REG_ULIMIT:   shadow_d.upper     = lane_merge(shadow_q.upper, dataIn, lane_we_c);
                    REG_LLIMIT:   shadow_d.lower     = lane_merge(shadow_q.lower, dataIn, lane_we_c);
                    REG_LOOPDATA: shadow_d.loop_data = lane_merge(shadow_q.loop_data, dataIn, lane_we_c);
                    REG_LOCKDET: begin
                        if (lane_we_c[0]) shadow_d.lock_count[7:0]  = dataIn[7:0];
                        if (lane_we_c[1]) shadow_d.lock_count[15:8] = dataIn[15:8];
                        if (lane_we_c[2]) shadow_d.sync_thr[7:0]    = dataIn[23:16];
                        if (lane_we_c[3]) shadow_d.sync_thr[11:8]   = dataIn[27:24];
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge busClk) begin
            if (!nReset) begin
                shadow_q  <= CFG_RST;
                active_q  <= CFG_RST;
                pending_q <= 1'b0;
                lost_q    <= 1'b0;
                lock_q    <= 1'b0;
                lock_d1_q <= 1'b0;
                clear_q   <= 1'b0;
                zero_q    <= 1'b0;
                inv_q     <= 1'b0;
                ctrl2_q   <= 1'b0;
                ctrl4_q   <= 1'b0;
                acq_q     <= 2'b00;
            end else begin
                shadow_q <= shadow_d;
                if (copy_c) active_q <= shadow_q;
                if (cfg_wr_c) pending_q <= 1'b1;
                else if (copy_c) pending_q <= 1'b0;
                clear_q <= clear_c;
                if (sel_c && (reg_sel_c == REG_CONTROL) && lane_we_c[0]) begin
                    zero_q  <= dataIn[0];
                    inv_q   <= dataIn[1];
                    ctrl2_q <= dataIn[2];
                    ctrl4_q <= dataIn[4];
                end
                if (sel_c && (reg_sel_c == REG_CONTROL) && lane_we_c[1]) acq_q <= dataIn[9:8];
                lock_q    <= lockStatus[c];
                lock_d1_q <= lock_q;
                // A fresh loss of lock beats a simultaneous clear.
                if (lock_d1_q && !lock_q) lost_q <= 1'b1;
                else if (w1c_c) lost_q <= 1'b0;
            end
        end

        always_comb begin
            rd_c = 32'h0;
            case (reg_sel_c)
                REG_CONTROL:    rd_c = {lockStatus[c], 21'h0, acq_q, 3'b000, ctrl4_q, 1'b0,
                                        ctrl2_q, inv_q, zero_q};
                REG_LEAD_LAG:   rd_c = {shadow_q.lead_man, 3'b000, shadow_q.lead_exp,
                                        shadow_q.lag_man, 3'b000, shadow_q.lag_exp};
                REG_ULIMIT:     rd_c = shadow_q.upper;
                REG_LLIMIT:     rd_c = shadow_q.lower;
                REG_LOOPDATA:   rd_c = shadow_q.loop_data;
                REG_LOCKDET:    rd_c = {4'h0, shadow_q.sync_thr, shadow_q.lock_count};
                REG_INTEGRATOR: rd_c = lagAccum[32*c +: 32];
                REG_STATUS:     rd_c = {30'h0, pending_q, lost_q};
                default:        rd_c = 32'h0;
            endcase
        end

        assign rd_word_c[c] = rd_c;

        assign zeroError[c]               = zero_q;
        assign invertError[c]             = inv_q;
        assign ctrl2[c]                   = ctrl2_q;
        assign ctrl4[c]                   = ctrl4_q;
        assign clearAccum[c]              = clear_q;
        assign acqTrackControl[2*c +: 2]  = acq_q;
        assign leadMan[8*c +: 8]          = active_q.lead_man;
        assign leadExp[5*c +: 5]          = active_q.lead_exp;
        assign lagMan[8*c +: 8]           = active_q.lag_man;
        assign lagExp[5*c +: 5]           = active_q.lag_exp;
        assign upperLimit[32*c +: 32]     = active_q.upper;
        assign lowerLimit[32*c +: 32]     = active_q.lower;
        assign loopData[32*c +: 32]       = active_q.loop_data;
        assign lockCount[16*c +: 16]      = active_q.lock_count;
        assign syncThreshold[12*c +: 12]  = active_q.sync_thr;
        assign lockLost[c]                = lost_q;
    end

    // Read mux: zero when deselected or addressing an unmapped channel.
    always_comb begin
        dataOut = 32'h0;
        if (cs && ch_ok_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (32'(ch_sel_c) == 32'(i)) dataOut = rd_word_c[i];
            end
        end
    end

endmodule
